// File: rtl/odd_down_counter.sv
// Loadable odd-only down-counter (N, N-2, ..., 1) with start/stop, auto-reload and terminal pulse.
// Latency: all outputs registered, one edge per step; no backpressure, strobes take effect on the next edge.
module odd_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO      = WIDTH'(2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             start_go;
  logic [WIDTH-1:0] load_odd;

  // stop dominates start; forcing the LSB keeps every captured value odd
  assign start_go = start & ~stop;
  assign load_odd = load_val | ONE;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_odd;
      reload_d = load_odd;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_go) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (count_q == ONE) begin
            // terminal step: 1 is never decremented, so count cannot wrap
            tc_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end else begin
            count_d = count_q - TWO;
          end
        end
        DONE: begin
          if (start_go) begin
            count_d = reload_q;
            state_d = RUN;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= ALL_ONES;
      reload_q <= ALL_ONES;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign tc    = tc_q;

endmodule

// File: tb/tb_odd_down_counter.sv
// Bench for odd_down_counter: hand-derived expected outputs queued per driven cycle, compared after the edge.
module tb_odd_down_counter;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  typedef struct packed {
    logic [7:0] count;
    logic       busy;
    logic       tc;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   total;
  int   bad;

  odd_down_counter #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog");
  end

  // Drives one cycle of stimulus, queues its expected result and records what the DUT shows after the edge.
  task automatic apply(input logic ld, input logic [7:0] val, input logic st, input logic sp,
                       input logic ar, input logic [7:0] ec, input logic eb, input logic et,
                       input logic ed);
    @(negedge clk);
    load        = ld;
    load_val    = val;
    start       = st;
    stop        = sp;
    auto_reload = ar;
    exp_q.push_back({ec, eb, et, ed});
    @(posedge clk);
    #1;
    obs_q.push_back({count, busy, tc, done});
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t o;
    int   i;
    rst_n = 1'b0;
    load = L; load_val = 8'h00; start = L; stop = L; auto_reload = L;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({count, busy, tc, done} !== {8'hFF, L, L, L}) begin
      bad++;
      $display("FAIL reset_hold: count=%h busy=%b tc=%b done=%b, required count=ff busy=0 tc=0 done=0",
               count, busy, tc, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) apply(L, 8'h00, L, L, L, 8'hFF, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_idle[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  task automatic test_basic_countdown();
    obs_t e;
    obs_t o;
    int   i;
    apply(H, 8'h07, L, L, L, 8'h07, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h07, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h05, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h03, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h01, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h01, L, H, H);
    apply(L, 8'h00, L, L, L, 8'h01, L, L, H);
    apply(L, 8'h00, L, H, L, 8'h01, L, L, H);
    apply(L, 8'h00, H, H, L, 8'h01, L, L, H);
    apply(L, 8'h00, H, L, L, 8'h07, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h05, H, L, L);
    apply(L, 8'h00, L, H, L, 8'h05, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  task automatic test_auto_reload();
    obs_t e;
    obs_t o;
    int   i;
    apply(H, 8'h05, L, L, H, 8'h05, L, L, L);
    apply(L, 8'h00, H, L, H, 8'h05, H, L, L);
    for (int k = 0; k < 3; k++) begin
      apply(L, 8'h00, L, L, H, 8'h03, H, L, L);
      apply(L, 8'h00, L, L, H, 8'h01, H, L, L);
      apply(L, 8'h00, L, L, H, 8'h05, H, H, L);
    end
    apply(L, 8'h00, L, L, H, 8'h03, H, L, L);
    apply(L, 8'h00, L, H, L, 8'h03, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL auto_reload[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  task automatic test_even_zero_priority();
    obs_t e;
    obs_t o;
    int   i;
    apply(H, 8'h06, L, L, L, 8'h07, L, L, L);
    apply(H, 8'h00, L, L, L, 8'h01, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h01, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h01, L, H, H);
    apply(L, 8'h00, L, L, L, 8'h01, L, L, H);
    apply(H, 8'hFE, H, L, L, 8'hFF, L, L, L);
    apply(L, 8'h00, L, L, L, 8'hFF, L, L, L);
    apply(L, 8'h00, H, L, L, 8'hFF, H, L, L);
    apply(L, 8'h00, L, L, L, 8'hFD, H, L, L);
    apply(H, 8'h03, H, H, L, 8'h03, L, L, L);
    apply(H, 8'h01, L, L, L, 8'h01, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h01, H, L, L);
    apply(H, 8'h08, L, L, H, 8'h09, L, L, L);
    apply(L, 8'h00, L, L, L, 8'h09, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL even_zero_prio[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  task automatic test_pause_stop_wins();
    obs_t e;
    obs_t o;
    int   i;
    apply(H, 8'h0B, L, L, L, 8'h0B, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h0B, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h09, H, L, L);
    apply(L, 8'h00, L, H, L, 8'h09, L, L, L);
    apply(L, 8'h00, H, H, L, 8'h09, L, L, L);
    apply(L, 8'h00, L, L, L, 8'h09, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h09, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h07, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h05, H, L, L);
    apply(L, 8'h00, H, H, L, 8'h05, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pause[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  task automatic test_async_reset();
    obs_t e;
    obs_t o;
    int   i;
    apply(H, 8'h35, L, L, L, 8'h35, L, L, L);
    apply(L, 8'h00, H, L, L, 8'h35, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h33, H, L, L);
    apply(L, 8'h00, L, L, L, 8'h31, H, L, L);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({count, busy, tc, done} !== {8'hFF, L, L, L}) begin
      bad++;
      $display("FAIL async_reset: count=%h busy=%b tc=%b done=%b, required count=ff busy=0 tc=0 done=0",
               count, busy, tc, done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) apply(L, 8'h00, L, L, L, 8'hFF, L, L, L);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL async_seq[%0d]: count=%h busy=%b tc=%b done=%b, required count=%h busy=%b tc=%b done=%b",
                 i, o.count, o.busy, o.tc, o.done, e.count, e.busy, e.tc, e.done);
      end
      i++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic_countdown();
    test_auto_reload();
    test_even_zero_priority();
    test_pause_stop_wins();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
